cpu_matrix_operand_fetch: RTL and testbench
===========================================

Name: cpu_matrix_operand_fetch

Overview:
Sequencer that gathers two MATRIX_SIZE x MATRIX_SIZE operand matrices (A and B) for the tensor core.
It drives the two read ports of the CPU register file and captures the combinational read data each cycle.
It delivers both matrices as flat row-major buses under a valid/ready handshake.
It sits between the register file read ports and the tensor-core compute stage.

Parameters:
NUMBER_OF_REGISTERS, 256, register file depth; address width is $clog2(NUMBER_OF_REGISTERS)
DATA_WIDTH, 8, element width; matches register file word width
MATRIX_SIZE, 4, matrix dimension; ELEMENTS = MATRIX_SIZE*MATRIX_SIZE = 16

Ports:
clock_in  input  1  single clock; all state changes on its rising edge
reset_n_in  input  1  asynchronous, active-low reset
start_in  input  1  request a fetch; sampled only when the block is accepting
base_address_a_in  input  AW  first register of matrix A; sampled at accept
base_address_b_in  input  AW  first register of matrix B; sampled at accept
read_register_address1_out  output  AW  drives register file read port 1 (A)
read_register_address2_out  output  AW  drives register file read port 2 (B)
read_data1_in  input  DATA_WIDTH  register file port 1 data; combinational, same cycle as address
read_data2_in  input  DATA_WIDTH  register file port 2 data; combinational, same cycle as address
matrix_a_out  output  ELEMENTS*DATA_WIDTH  element i at bits [i*DATA_WIDTH +: DATA_WIDTH], i = row*MATRIX_SIZE + col
matrix_b_out  output  ELEMENTS*DATA_WIDTH  same packing as matrix_a_out
valid_out  output  1  both matrices complete and stable
ready_in  input  1  consumer accepts the matrices
busy_out  output  1  high in FETCH

Behaviour:
- Reset (asynchronous, any state): state=IDLE, index=0, base registers=0, matrix_a_out=0, matrix_b_out=0, valid_out=0, busy_out=0, both read addresses=0.
- States:
  - IDLE: accepting.
  - FETCH: busy_out=1.
  - DONE: valid_out=1.
- IDLE: if start_in=1 at an edge, latch both bases, set index=0, go to FETCH. Read addresses are driven to 0 while in IDLE.
- FETCH:
  - read_register_address1_out = (base_a + index) mod NUMBER_OF_REGISTERS; read_register_address2_out uses base_b the same way. Both are driven from registers/index only, with no path from start_in.
  - At each edge, read_data1_in is stored into A element[index] and read_data2_in into B element[index], then index increments.
  - At the edge where index = ELEMENTS-1 is captured, go to DONE and reset index to 0.
- Latency: start accepted at edge E0, elements captured at E1..E16, valid_out high from E16 onward. That is exactly ELEMENTS cycles from acceptance.
- DONE:
  - valid_out=1. matrix outputs are held stable until the transfer.
  - Transfer occurs on an edge with valid_out=1 and ready_in=1.
  - After the transfer, go to IDLE with valid_out=0. Matrix contents are retained; they are not cleared.
  - If start_in=1 on the transfer edge, accept the new request directly: go to FETCH and latch the new bases (back-to-back).
- start_in during FETCH, or during DONE without ready_in, is ignored: no latch and no queueing.
- Address wrap: the base+index addition is truncated to AW bits. Base 0xF8 reads 0xF8..0xFF, then 0x00..0x07.
- Register 0 reads return whatever the register file supplies (zero); no special casing here.
- A and B ranges may overlap or be identical; no restriction.
- Matrix outputs are only partially updated during FETCH. Consumers must qualify them with valid_out.
- Register file writes that occur during FETCH are visible if they land before the element is read. No hazard detection is performed.

Decomposition:
- Shared package cpu_tensor_pkg holds:
  - DATA_WIDTH, MATRIX_SIZE, ELEMENTS and the register address width constant.
  - The state enum fetch_state_t {IDLE, FETCH, DONE}.
  - A typedef for the flat matrix bus.
- No sub-module. Both ports use identical address-generate/capture logic; implement it as a generate loop, not a separate module.

Test Plan:
- Basic fetch: preload reg[0x10+i]=i+1 and reg[0x20+i]=0x80+i; start with A=0x10, B=0x20, ready_in=1.
  -> busy_out for 16 cycles; valid_out 16 cycles after accept; matrix_a element i = i+1, matrix_b element i = 0x80+i; IDLE next cycle.
- Wrap-around: preload reg[n]=n for n=1..255; start with A=0xF8, B=0xFC.
  -> A elements = F8..FF,00..07 with element 8 = 0; B element 4 = 0, element 15 = 0x0B.
- Backpressure: hold ready_in=0 for 5 cycles after valid_out rises.
  -> valid_out and both matrices unchanged every cycle; transfer on the first ready_in=1 edge, then valid_out=0.
- Ignored start: pulse start_in with different bases at FETCH index 7.
  -> read addresses continue from the original bases; the result matches the first request only.
- Back-to-back: hold start_in=1 with ready_in=1 at DONE.
  -> valid_out low for exactly 16 cycles; the second matrix set reflects the new bases.
- Reset mid-fetch: deassert reset_n_in asynchronously at index 9.
  -> all outputs 0 immediately; after release the block is in IDLE, and a new start completes correctly in 16 cycles.

Source files
------------

// File: rtl/cpu_tensor_pkg.sv
// rtl/cpu_tensor_pkg.sv - shared constants and types for the tensor-core operand path
package cpu_tensor_pkg;

   localparam int NUMBER_OF_REGISTERS = 256;
   localparam int REG_ADDR_WIDTH      = $clog2(NUMBER_OF_REGISTERS);
   localparam int DATA_WIDTH          = 8;
   localparam int MATRIX_SIZE         = 4;
   localparam int ELEMENTS            = MATRIX_SIZE * MATRIX_SIZE;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DONE
   } fetch_state_t;

   typedef logic [ELEMENTS*DATA_WIDTH-1:0] matrix_bus_t;

endpackage

// File: rtl/cpu_matrix_operand_fetch.sv
// rtl/cpu_matrix_operand_fetch.sv - gathers two row-major operand matrices from the register file
module cpu_matrix_operand_fetch #(
   parameter int NUMBER_OF_REGISTERS = cpu_tensor_pkg::NUMBER_OF_REGISTERS,
   parameter int DATA_WIDTH          = cpu_tensor_pkg::DATA_WIDTH,
   parameter int MATRIX_SIZE         = cpu_tensor_pkg::MATRIX_SIZE
) (
   input  logic                                               clock_in,
   input  logic                                               reset_n_in,
   input  logic                                               start_in,
   input  logic [$clog2(NUMBER_OF_REGISTERS)-1:0]             base_address_a_in,
   input  logic [$clog2(NUMBER_OF_REGISTERS)-1:0]             base_address_b_in,
   output logic [$clog2(NUMBER_OF_REGISTERS)-1:0]             read_register_address1_out,
   output logic [$clog2(NUMBER_OF_REGISTERS)-1:0]             read_register_address2_out,
   input  logic [DATA_WIDTH-1:0]                              read_data1_in,
   input  logic [DATA_WIDTH-1:0]                              read_data2_in,
   output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]      matrix_a_out,
   output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]      matrix_b_out,
   output logic                                               valid_out,
   input  logic                                               ready_in,
   output logic                                               busy_out
);
   import cpu_tensor_pkg::*;

   localparam int AW    = $clog2(NUMBER_OF_REGISTERS);
   localparam int ELEMS = MATRIX_SIZE * MATRIX_SIZE;
   localparam int IW    = (ELEMS > 1) ? $clog2(ELEMS) : 1;
   localparam int MW    = ELEMS * DATA_WIDTH;
   localparam logic [IW-1:0] LAST_INDEX = IW'(ELEMS - 1);

   fetch_state_t  state;
   fetch_state_t  next_state;
   logic [IW-1:0] index;
   logic [IW-1:0] next_index;
   logic          accept;

   logic [AW-1:0]         base_sel [2];
   logic [DATA_WIDTH-1:0] data_sel [2];
   logic [AW-1:0]         addr     [2];
   logic [MW-1:0]         mat      [2];

   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state <= IDLE;
         index <= '0;
      end else begin
         state <= next_state;
         index <= next_index;
      end
   end

   // A transfer edge that also sees start_in goes straight back to FETCH.
   always_comb begin
      next_state = state;
      next_index = index;
      accept     = 1'b0;
      busy_out   = 1'b0;
      valid_out  = 1'b0;
      case (state)
         IDLE: begin
            if (start_in) begin
               accept     = 1'b1;
               next_state = FETCH;
               next_index = '0;
            end
         end
         FETCH: begin
            busy_out = 1'b1;
            if (index == LAST_INDEX) begin
               next_state = DONE;
               next_index = '0;
            end else begin
               next_index = index + 1'b1;
            end
         end
         DONE: begin
            valid_out = 1'b1;
            if (ready_in) begin
               if (start_in) begin
                  accept     = 1'b1;
                  next_state = FETCH;
                  next_index = '0;
               end else begin
                  next_state = IDLE;
               end
            end
         end
         default: begin
            next_state = IDLE;
            next_index = '0;
         end
      endcase
   end

   assign base_sel[0] = base_address_a_in;
   assign base_sel[1] = base_address_b_in;
   assign data_sel[0] = read_data1_in;
   assign data_sel[1] = read_data2_in;

   for (genvar p = 0; p < 2; p++) begin : g_port
      logic [AW-1:0] base_q;
      logic [MW-1:0] mat_q;

      always_ff @(posedge clock_in or negedge reset_n_in) begin
         if (!reset_n_in) begin
            base_q <= '0;
            mat_q  <= '0;
         end else begin
            if (accept) begin
               base_q <= base_sel[p];
            end
            if (state == FETCH) begin
               mat_q[int'(index)*DATA_WIDTH +: DATA_WIDTH] <= data_sel[p];
            end
         end
      end

      // Sum truncates to AW bits so a range near the top wraps to register 0.
      assign addr[p] = (state == FETCH) ? (base_q + AW'(index)) : '0;
      assign mat[p]  = mat_q;
   end

   assign read_register_address1_out = addr[0];
   assign read_register_address2_out = addr[1];
   assign matrix_a_out               = mat[0];
   assign matrix_b_out               = mat[1];

endmodule

// File: tb/tb_cpu_matrix_operand_fetch.sv
// tb/tb_cpu_matrix_operand_fetch.sv - scoreboard bench for the matrix operand fetch sequencer
module tb_cpu_matrix_operand_fetch;
   import cpu_tensor_pkg::*;

   logic        clock_in = 1'b0;
   logic        reset_n_in = 1'b0;
   logic        start_in = 1'b0;
   logic        ready_in = 1'b0;
   logic [7:0]  base_address_a_in = 8'h00;
   logic [7:0]  base_address_b_in = 8'h00;
   logic [7:0]  read_register_address1_out;
   logic [7:0]  read_register_address2_out;
   logic [7:0]  read_data1_in;
   logic [7:0]  read_data2_in;
   matrix_bus_t matrix_a_out;
   matrix_bus_t matrix_b_out;
   logic        valid_out;
   logic        busy_out;

   logic [7:0]  rf [256];
   matrix_bus_t exp_a_q [$];
   matrix_bus_t exp_b_q [$];
   int          tests = 0;
   int          fails = 0;

   always #5 clock_in = ~clock_in;

   assign read_data1_in = rf[read_register_address1_out];
   assign read_data2_in = rf[read_register_address2_out];

   cpu_matrix_operand_fetch dut (
      .clock_in                   (clock_in),
      .reset_n_in                 (reset_n_in),
      .start_in                   (start_in),
      .base_address_a_in          (base_address_a_in),
      .base_address_b_in          (base_address_b_in),
      .read_register_address1_out (read_register_address1_out),
      .read_register_address2_out (read_register_address2_out),
      .read_data1_in              (read_data1_in),
      .read_data2_in              (read_data2_in),
      .matrix_a_out               (matrix_a_out),
      .matrix_b_out               (matrix_b_out),
      .valid_out                  (valid_out),
      .ready_in                   (ready_in),
      .busy_out                   (busy_out)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk(name, {127'd0, act}, {127'd0, exp});
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      chk(name, {120'd0, act}, {120'd0, exp});
   endtask

   // Expected bus when every register n holds the value n.
   function automatic matrix_bus_t identity_bus(input logic [7:0] base);
      matrix_bus_t bus;
      for (int i = 0; i < ELEMENTS; i++) bus[i*8 +: 8] = base + 8'(i);
      return bus;
   endfunction

   // Scoreboard monitor: a transfer is committed on the next edge when both are high here.
   always @(negedge clock_in) begin
      if (reset_n_in && valid_out && ready_in) begin
         if (exp_a_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_transfer: got a=%h expected no transfer", matrix_a_out);
         end else begin
            chk("matrix_a", matrix_a_out, exp_a_q.pop_front());
            chk("matrix_b", matrix_b_out, exp_b_q.pop_front());
         end
      end
   end

   task automatic push_exp(input matrix_bus_t ea, input matrix_bus_t eb);
      exp_a_q.push_back(ea);
      exp_b_q.push_back(eb);
   endtask

   task automatic fetch(input logic [7:0] a, input logic [7:0] b);
      base_address_a_in = a;
      base_address_b_in = b;
      start_in = 1'b1;
      @(posedge clock_in);
      #1 start_in = 1'b0;
      for (int k = 0; k < ELEMENTS; k++) begin
         @(negedge clock_in);
         chk1("busy_fetch", busy_out, 1'b1);
         chk1("valid_fetch", valid_out, 1'b0);
         chk8("addr1_fetch", read_register_address1_out, a + 8'(k));
         chk8("addr2_fetch", read_register_address2_out, b + 8'(k));
      end
      @(negedge clock_in);
      chk1("valid_rise", valid_out, 1'b1);
      chk1("busy_done", busy_out, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      matrix_bus_t ea;
      matrix_bus_t eb;
      for (int n = 0; n < 256; n++) rf[n] = 8'h00;
      for (int i = 0; i < ELEMENTS; i++) begin
         rf[8'h10 + i] = 8'(i + 1);
         rf[8'h20 + i] = 8'(8'h80 + i);
      end

      #3;
      chk1("rst_valid", valid_out, 1'b0);
      chk1("rst_busy", busy_out, 1'b0);
      chk8("rst_addr1", read_register_address1_out, 8'h00);
      chk8("rst_addr2", read_register_address2_out, 8'h00);
      chk("rst_mat_a", matrix_a_out, '0);
      chk("rst_mat_b", matrix_b_out, '0);
      @(posedge clock_in);
      #1 reset_n_in = 1'b1;
      ready_in = 1'b1;

      // basic fetch
      for (int i = 0; i < ELEMENTS; i++) begin
         ea[i*8 +: 8] = 8'(i + 1);
         eb[i*8 +: 8] = 8'(8'h80 + i);
      end
      push_exp(ea, eb);
      fetch(8'h10, 8'h20);
      @(negedge clock_in);
      chk1("basic_idle_valid", valid_out, 1'b0);
      chk1("basic_idle_busy", busy_out, 1'b0);
      chk8("basic_idle_addr1", read_register_address1_out, 8'h00);

      for (int n = 0; n < 256; n++) rf[n] = 8'(n);

      // wrap-around
      push_exp(identity_bus(8'hF8), identity_bus(8'hFC));
      fetch(8'hF8, 8'hFC);
      @(negedge clock_in);
      chk1("wrap_idle_valid", valid_out, 1'b0);

      // backpressure
      @(posedge clock_in);
      #1 ready_in = 1'b0;
      push_exp(identity_bus(8'h40), identity_bus(8'h50));
      fetch(8'h40, 8'h50);
      for (int c = 0; c < 5; c++) begin
         @(negedge clock_in);
         chk1("bp_valid_hold", valid_out, 1'b1);
         chk("bp_mat_a_hold", matrix_a_out, identity_bus(8'h40));
         chk("bp_mat_b_hold", matrix_b_out, identity_bus(8'h50));
      end
      @(posedge clock_in);
      #1 ready_in = 1'b1;
      @(negedge clock_in);
      @(negedge clock_in);
      chk1("bp_after_valid", valid_out, 1'b0);

      // start pulse during FETCH is ignored
      push_exp(identity_bus(8'h30), identity_bus(8'h60));
      base_address_a_in = 8'h30;
      base_address_b_in = 8'h60;
      start_in = 1'b1;
      @(posedge clock_in);
      #1 start_in = 1'b0;
      repeat (7) @(posedge clock_in);
      #1;
      base_address_a_in = 8'h90;
      base_address_b_in = 8'hA0;
      start_in = 1'b1;
      @(negedge clock_in);
      chk8("ign_addr1_i7", read_register_address1_out, 8'h37);
      chk8("ign_addr2_i7", read_register_address2_out, 8'h67);
      @(posedge clock_in);
      #1 start_in = 1'b0;
      @(negedge clock_in);
      chk8("ign_addr1_i8", read_register_address1_out, 8'h38);
      chk8("ign_addr2_i8", read_register_address2_out, 8'h68);
      chk1("ign_busy", busy_out, 1'b1);
      repeat (8) @(posedge clock_in);
      @(negedge clock_in);
      chk1("ign_valid", valid_out, 1'b1);
      @(negedge clock_in);
      chk1("ign_after_valid", valid_out, 1'b0);
      chk1("ign_after_busy", busy_out, 1'b0);

      // back-to-back
      push_exp(identity_bus(8'h00), identity_bus(8'h70));
      base_address_a_in = 8'h00;
      base_address_b_in = 8'h70;
      start_in = 1'b1;
      @(posedge clock_in);
      #1;
      push_exp(identity_bus(8'hC0), identity_bus(8'hD0));
      base_address_a_in = 8'hC0;
      base_address_b_in = 8'hD0;
      repeat (16) @(posedge clock_in);
      @(negedge clock_in);
      chk1("b2b_valid1", valid_out, 1'b1);
      @(posedge clock_in);
      #1 start_in = 1'b0;
      for (int k = 0; k < ELEMENTS; k++) begin
         @(negedge clock_in);
         chk1("b2b_valid_gap", valid_out, 1'b0);
         chk8("b2b_addr1", read_register_address1_out, 8'hC0 + 8'(k));
      end
      @(negedge clock_in);
      chk1("b2b_valid2", valid_out, 1'b1);
      @(negedge clock_in);
      chk1("b2b_after_valid", valid_out, 1'b0);

      // asynchronous reset mid-fetch
      base_address_a_in = 8'h10;
      base_address_b_in = 8'h20;
      start_in = 1'b1;
      @(posedge clock_in);
      #1 start_in = 1'b0;
      repeat (9) @(posedge clock_in);
      #3 reset_n_in = 1'b0;
      #1;
      chk1("arst_valid", valid_out, 1'b0);
      chk1("arst_busy", busy_out, 1'b0);
      chk8("arst_addr1", read_register_address1_out, 8'h00);
      chk8("arst_addr2", read_register_address2_out, 8'h00);
      chk("arst_mat_a", matrix_a_out, '0);
      chk("arst_mat_b", matrix_b_out, '0);
      @(posedge clock_in);
      #1 reset_n_in = 1'b1;
      @(negedge clock_in);
      chk1("arst_idle_busy", busy_out, 1'b0);
      chk1("arst_idle_valid", valid_out, 1'b0);
      push_exp(identity_bus(8'h05), identity_bus(8'h15));
      fetch(8'h05, 8'h15);
      @(negedge clock_in);
      chk1("arst_after_valid", valid_out, 1'b0);

      repeat (3) @(negedge clock_in);
      chk("queue_empty", 128'(exp_a_q.size()), 128'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
